// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Multiplexed 4-digit 7-segment display controller. One BCD-to-segment
//   decoder is time-shared across four digits. Each digit slot is active for
//   SCAN_DIV clock cycles, so one frame lasts 4*SCAN_DIV cycles. A new value
//   written during a frame is held in a shadow register and only reaches the
//   display register at the frame boundary, which prevents tearing.
//
// Parameters
//   SCAN_DIV    clock cycles per digit slot (legal range 2..1024)
//
// Ports
//   clk         system clock, rising-edge active
//   reset       asynchronous, active-low reset
//   load        single-cycle strobe qualifying data_in
//   data_in     four BCD nibbles, digit0 = [3:0] ... digit3 = [15:12]
//   blank       level; forces segOut and digitEn low in the same cycle
//   segOut      segment pattern gfedcba, active-high (decoded from registers)
//   digitEn     one-hot digit enable, active-high (decoded from registers)
//   frame_done  registered one-cycle pulse on the first cycle of a new frame
//   pending     registered; high while a loaded value waits in the shadow
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blank,
  output logic [6:0]  segOut,
  output logic [3:0]  digitEn,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIGIT_W  = 2;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SEG_W    = 7;

  localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(3);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Registered state
  state_t              state_q;
  logic [DIGIT_W-1:0]  idx_q;
  logic [CNT_W-1:0]    slot_q;
  logic [DATA_W-1:0]   disp_q;
  logic [DATA_W-1:0]   shadow_q;
  logic                pend_q;
  logic                fd_q;

  // Next-state values
  state_t              state_d;
  logic [DIGIT_W-1:0]  idx_d;
  logic [CNT_W-1:0]    slot_d;
  logic [DATA_W-1:0]   disp_d;
  logic [DATA_W-1:0]   shadow_d;
  logic                pend_d;
  logic                fd_d;

  // Last cycle of the frame: digit 3, final slot cycle
  logic boundary_c;
  assign boundary_c = (idx_q == DIGIT_LAST) && (slot_q == SLOT_LAST);

  // BCD nibble to gfedcba; non-decimal codes show a dash
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      slot_q   <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      fd_q     <= fd_d;
    end
  end

  // Next-state logic: scan timing, shadow capture and frame-boundary update
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    fd_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // First load goes straight to the display; no frame is in flight
        if (load) begin
          disp_d  = data_in;
          state_d = SCAN;
          idx_d   = '0;
          slot_d  = '0;
          pend_d  = 1'b0;
        end
      end

      SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          idx_d  = idx_q + DIGIT_W'(1);
        end else begin
          slot_d = slot_q + CNT_W'(1);
        end

        if (boundary_c) begin
          // A load coinciding with the boundary is newer than anything pending
          fd_d   = 1'b1;
          pend_d = 1'b0;
          if (load) begin
            disp_d = data_in;
          end else if (pend_q) begin
            disp_d = shadow_q;
          end
        end else if (load) begin
          // Last load in a frame overwrites any earlier one
          shadow_d = data_in;
          pend_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registers; blank overrides in the same cycle
  logic [3:0] nibble_c;
  always_comb begin
    nibble_c = 4'h0;
    case (idx_q)
      2'd0:    nibble_c = disp_q[3:0];
      2'd1:    nibble_c = disp_q[7:4];
      2'd2:    nibble_c = disp_q[11:8];
      default: nibble_c = disp_q[15:12];
    endcase
  end

  always_comb begin
    segOut  = '0;
    digitEn = '0;
    if ((state_q == SCAN) && !blank) begin
      digitEn = 4'b0001 << idx_q;
      // Slot cycle 0 is dead time so the previous digit cannot ghost
      if (slot_q != '0) begin
        segOut = bcd_to_seg(nibble_c);
      end
    end
  end

  assign frame_done = fd_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with SCAN_DIV=4. The driver issues one
//   input vector per clock and pushes the expected output observation for
//   that cycle; an independent monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int unsigned D = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] en;
    logic       fd;
    logic       pend;
  } obs_t;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] data_in;
  logic        blank;
  logic [6:0]  segOut;
  logic [3:0]  digitEn;
  logic        frame_done;
  logic        pending;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    failures;

  seg_scan_ctrl #(.SCAN_DIV(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .blank      (blank),
    .segOut     (segOut),
    .digitEn    (digitEn),
    .frame_done (frame_done),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push an expected observation for the current cycle
  task automatic expect_now(input logic [6:0] seg, input logic [3:0] en,
                            input logic fd, input logic pend, input string nm);
    obs_t e;
    e.seg  = seg;
    e.en   = en;
    e.fd   = fd;
    e.pend = pend;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Drive one cycle of inputs with its expected outputs, then advance
  task automatic cyc(input logic ld, input logic [15:0] d, input logic bl,
                     input logic [6:0] seg, input logic [3:0] en,
                     input logic fd, input logic pend, input string nm);
    load    = ld;
    data_in = d;
    blank   = bl;
    expect_now(seg, en, fd, pend, nm);
    @(posedge clk);
    #1;
    load    = 1'b0;
    blank   = 1'b0;
  endtask

  // One frame (or its first ncyc cycles) of a displayed value.
  // s0..s3 are hand-decoded segment patterns for digits 0..3.
  // Up to two loads (cycles la, lb; -1 = none) and a blank window [bl_lo, bl_hi].
  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3,
                       input logic fd_first,
                       input int la, input logic [15:0] da,
                       input int lb, input logic [15:0] db,
                       input int bl_lo, input int bl_hi,
                       input int ncyc, input string nm);
    logic [6:0] segs [4];
    logic       pend_e;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    pend_e  = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      int         d;
      int         s;
      logic       ld;
      logic       bl;
      logic [15:0] dat;
      logic [6:0] seg;
      logic [3:0] en;
      logic       fd;
      d   = k / D;
      s   = k % D;
      ld  = (k == la) || (k == lb);
      dat = (k == la) ? da : db;
      bl  = (k >= bl_lo) && (k <= bl_hi);
      seg = (bl || s == 0) ? 7'h00 : segs[d];
      en  = bl ? 4'b0000 : 4'(1 << d);
      fd  = (k == 0) && fd_first;
      cyc(ld, dat, bl, seg, en, fd, pend_e, nm);
      if (ld && k < 4 * D - 1) pend_e = 1'b1;
    end
  endtask

  // Monitor: compare each pushed expectation against the DUT mid-cycle
  initial begin
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t  e;
        obs_t  a;
        string n;
        e      = exp_q.pop_front();
        n      = name_q.pop_front();
        a.seg  = segOut;
        a.en   = digitEn;
        a.fd   = frame_done;
        a.pend = pending;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s t=%0t: got seg=%h en=%b fd=%b pend=%b, want seg=%h en=%b fd=%b pend=%b",
                   n, $time, a.seg, a.en, a.fd, a.pend, e.seg, e.en, e.fd, e.pend);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset   = 1'b0;
    load    = 1'b0;
    data_in = 16'h0000;
    blank   = 1'b0;
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset with no load: everything stays dark
    for (int i = 0; i < 100; i++) cyc(1'b0, 16'h0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, "idle_no_load");

    // Load 1234 from IDLE; outputs still dark in the load cycle
    cyc(1'b1, 16'h1234, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, "idle_load");
    frame(7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, -1, 16'h0, -1, 16'h0, -1, -1, 16, "f1_1234");

    // Two mid-frame loads, last wins; frame unchanged while pending
    frame(7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1, 3, 16'h1111, 6, 16'h5678, -1, -1, 16, "f2_midload");

    // 5678 shown; older 0000 pending, then 9999 loaded in the boundary cycle
    frame(7'h7F, 7'h07, 7'h7D, 7'h6D, 1'b1, 5, 16'h0000, 15, 16'h9999, -1, -1, 16, "f3_5678");

    // 9999 shown; load A0A0 mid-frame
    frame(7'h6F, 7'h6F, 7'h6F, 7'h6F, 1'b1, 2, 16'hA0A0, -1, 16'h0, -1, -1, 16, "f4_9999");

    // A0A0 shown with a 3-cycle blank spanning the digit0/digit1 change
    frame(7'h3F, 7'h40, 7'h3F, 7'h40, 1'b1, -1, 16'h0, -1, 16'h0, 3, 5, 16, "f5_a0a0_blank");

    // Run into digit 2 then pull reset asynchronously mid-cycle
    frame(7'h3F, 7'h40, 7'h3F, 7'h40, 1'b1, -1, 16'h0, -1, 16'h0, -1, -1, 10, "f6_pre_reset");
    reset = 1'b0;
    expect_now(7'h00, 4'h0, 1'b0, 1'b0, "async_reset");
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, "reset_held");
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) cyc(1'b0, 16'h0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, "post_reset_idle");

    // Load in the very first cycle after another reset release
    reset = 1'b0;
    #2;
    reset = 1'b1;
    cyc(1'b1, 16'h0042, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, "load_after_reset");
    frame(7'h5B, 7'h66, 7'h3F, 7'h3F, 1'b0, -1, 16'h0, -1, 16'h0, -1, -1, 16, "f7_0042");
    frame(7'h5B, 7'h66, 7'h3F, 7'h3F, 1'b1, -1, 16'h0, -1, 16'h0, -1, -1, 2, "f8_wrap");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
